// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one word-aligned req/gnt/rvalid bus transaction per access,
// with byte/half/word lane handling. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.

module lsu_lane #(parameter int LANE = 0) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] byte_src,
  input  logic [7:0] half_src,
  input  logic [7:0] word_src,
  output logic       be,
  output logic [7:0] wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    be    = 1'b1;
    wbyte = word_src;
    case (size)
      2'b00: begin be = (off == L);       wbyte = byte_src; end
      2'b01: begin be = (off[1] == L[1]); wbyte = half_src; end
      default: ;
    endcase
  end
endmodule

module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [31:0]           ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  // size: 00 byte, 01 half, 10 word; off: first byte lane of the access
  typedef struct packed {
    logic [1:0] size;
    logic       sext;
    logic [1:0] off;
  } req_t;

  state_t state, state_nxt;
  req_t   req, req_nxt;
  logic   access, trap;
  logic [1:0]                      a;
  logic [NUM_LANES-1:0]            be_nxt;
  logic [NUM_LANES-1:0][VEC_W-1:0] wdata_nxt, rlanes;
  logic [VEC_W-1:0]                lb;
  logic [2*VEC_W-1:0]              lh;
  logic [31:0]                     load_val;

  assign access = MemReadM | MemWriteM;
  assign a      = ALUResultM[1:0];

  // Misaligned low bits are dropped: half uses a[1], word uses lane 0.
  always_comb begin
    req_nxt      = '0;
    req_nxt.sext = ~funct3M[2];
    case (funct3M[1:0])
      2'b00:   begin req_nxt.size = 2'b00; req_nxt.off = a; end
      2'b01:   begin req_nxt.size = 2'b01; req_nxt.off = {a[1], 1'b0}; end
      default: req_nxt.size = 2'b10;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .size     (req_nxt.size),
      .off      (req_nxt.off),
      .byte_src (WriteDataM[VEC_W-1:0]),
      .half_src (WriteDataM[VEC_W*(i%2) +: VEC_W]),
      .word_src (WriteDataM[VEC_W*i +: VEC_W]),
      .be       (be_nxt[i]),
      .wbyte    (wdata_nxt[i])
    );
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (funct3M[1:0] == 2'b01) ? a[0] : (funct3M[1] && (a != 2'b00));
  assign trap       = access & misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) MisalignM <= 1'b0;
    else        MisalignM <= (state == IDLE) & trap;
  end
`else
  assign trap      = 1'b0;
  assign MisalignM = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      IDLE: if (access) state_nxt = trap ? DONE : REQ;
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = mem_we ? DONE : RESP;
      end
      RESP:    if (mem_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign StallM = access & (state != DONE);

  assign rlanes = mem_rdata;
  assign lb     = rlanes[req.off];
  assign lh     = {rlanes[{req.off[1], 1'b1}], rlanes[{req.off[1], 1'b0}]};

  always_comb begin
    case (req.size)
      2'b00:   load_val = {{24{req.sext & lb[7]}}, lb};
      2'b01:   load_val = {{16{req.sext & lh[15]}}, lh};
      default: load_val = mem_rdata;
    endcase
  end

  // Bus outputs are captured once in IDLE so they stay frozen through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
    end else begin
      if (state == IDLE && access && !trap) begin
        req       <= req_nxt;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
      end
      if (state == IDLE && trap && !MemWriteM) ReadDataM <= '0;
      else if (state == RESP && mem_rvalid)    ReadDataM <= load_val;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized accesses
// checked against a byte-arithmetic reference model.

module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_lsu #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall;
    bit          req_seen;
    bit          stable;
    bit          rd_early;
    bit          misal;
    bit          timeout;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdm;
  } obs_t;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = m_size(f3);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = m_size(f3);
    return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n, off;
    n = m_size(f3);
    off = m_off(f3, a);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdat);
    longint v;
    int n, off;
    n = m_size(f3);
    off = m_off(f3, a);
    v = longint'(rdat >> (8 * off)) % (longint'(1) << (8 * n));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- stimulus / bus responder ----------------
  // Drives one access, answers the bus with gnt after gd REQ cycles and rvalid after rd
  // RESP cycles, and records what the DUT did. noise raises rvalid during REQ waits.
  task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                            input int gd, input int rd, input bit noise, output obs_t o);
    int reqc, rc;
    bit granted;
    logic [31:0] rd0;
    o = '{default: '0};
    o.stable = 1'b1;
    reqc = 0; rc = 0; granted = 1'b0;
    @(negedge clk);
    rd0 = ReadDataM;
    MemReadM = ld; MemWriteM = st; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    mem_rdata = rdat;
    for (int c = 0; c <= 200; c++) begin
      #1;
      if (c == 200) begin o.timeout = 1'b1; break; end
      if (!StallM) begin o.misal = MisalignM; o.rdm = ReadDataM; break; end
      o.stall++;
      if (ReadDataM !== rd0) o.rd_early = 1'b1;
      if (mem_req) begin
        if (!o.req_seen) begin
          o.req_seen = 1'b1;
          o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o.addr, o.be, o.wdata, o.we})
          o.stable = 1'b0;
        if (reqc == gd) begin mem_gnt = 1'b1; granted = !st; end
        else if (noise) mem_rvalid = 1'b1;
        reqc++;
      end else if (granted) begin
        if (rc == rd) mem_rvalid = 1'b1;
        rc++;
      end
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
    @(negedge clk);
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem_req !== 1'b0)    begin n_err++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0)  begin n_err++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (mem_be !== 4'h0)     begin n_err++; $display("FAIL rst_be got=%b exp=0", mem_be); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
    n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL rst_rdm got=%h exp=0", ReadDataM); end
    n_cmp++; if (MisalignM !== 1'b0)  begin n_err++; $display("FAIL rst_misal got=%b exp=0", MisalignM); end
    n_cmp++; if (StallM !== 1'b0)     begin n_err++; $display("FAIL rst_stall got=%b exp=0", StallM); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sw();
    obs_t o;
    run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, o);
    n_cmp++; if (o.addr !== 32'h104)      begin n_err++; $display("FAIL sw_addr got=%h exp=104", o.addr); end
    n_cmp++; if (o.be !== 4'b1111)        begin n_err++; $display("FAIL sw_be got=%b exp=1111", o.be); end
    n_cmp++; if (o.wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata got=%h exp=deadbeef", o.wdata); end
    n_cmp++; if (o.we !== 1'b1)           begin n_err++; $display("FAIL sw_we got=%b exp=1", o.we); end
    n_cmp++; if (o.stall !== 2)           begin n_err++; $display("FAIL sw_stall got=%0d exp=2", o.stall); end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0, o);
    n_cmp++; if (o.rdm !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data got=%h exp=ffffff80", o.rdm); end
    n_cmp++; if (o.stall !== 3)          begin n_err++; $display("FAIL lb_stall got=%0d exp=3", o.stall); end
    n_cmp++; if (o.we !== 1'b0)          begin n_err++; $display("FAIL lb_we got=%b exp=0", o.we); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0, o);
    n_cmp++; if (o.rdm !== 32'h00000080) begin n_err++; $display("FAIL lbu_data got=%h exp=00000080", o.rdm); end
    n_cmp++; if (o.stall !== 3)          begin n_err++; $display("FAIL lbu_stall got=%0d exp=3", o.stall); end
  endtask

  task automatic test_sh_lhu();
    obs_t o;
    run_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 0, 0, 1'b0, o);
    n_cmp++; if (o.be !== 4'b1100)        begin n_err++; $display("FAIL sh_be got=%b exp=1100", o.be); end
    n_cmp++; if (o.wdata !== 32'hABCDABCD) begin n_err++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o.wdata); end
    n_cmp++; if (o.addr !== 32'h20)       begin n_err++; $display("FAIL sh_addr got=%h exp=20", o.addr); end
    n_cmp++; if (o.rdm !== 32'h00000080)  begin n_err++; $display("FAIL sh_keeps_rdm got=%h exp=00000080", o.rdm); end
    run_access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'hABCD0000, 0, 0, 1'b0, o);
    n_cmp++; if (o.rdm !== 32'h0000ABCD)  begin n_err++; $display("FAIL lhu_data got=%h exp=0000abcd", o.rdm); end
  endtask

  task automatic test_delayed();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b001, 32'h1A6, 32'h0, 32'h80017FFE, 3, 2, 1'b1, o);
    n_cmp++; if (o.stable !== 1'b1)      begin n_err++; $display("FAIL dly_stable got=%b exp=1", o.stable); end
    n_cmp++; if (o.stall !== 8)          begin n_err++; $display("FAIL dly_stall got=%0d exp=8", o.stall); end
    n_cmp++; if (o.rd_early !== 1'b0)    begin n_err++; $display("FAIL dly_early got=%b exp=0", o.rd_early); end
    n_cmp++; if (o.rdm !== 32'hFFFF8001) begin n_err++; $display("FAIL dly_data got=%h exp=ffff8001", o.rdm); end
    n_cmp++; if (o.timeout !== 1'b0)     begin n_err++; $display("FAIL dly_timeout got=%b exp=0", o.timeout); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h200;
    mem_rdata = 32'h12345678;
    @(negedge clk); #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_req_on got=%b exp=1", mem_req); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    // now waiting in RESP; pulse reset between clock edges
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0)    begin n_err++; $display("FAIL rmid_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0)  begin n_err++; $display("FAIL rmid_addr got=%h exp=0", mem_addr); end
    #1;
    reset = 1'b1;
    MemReadM = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL rmid_rdm got=%h exp=0", ReadDataM); end
    n_cmp++; if (mem_req !== 1'b0)    begin n_err++; $display("FAIL rmid_idle_req got=%b exp=0", mem_req); end
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 0, 0, 1'b0, o);
    n_cmp++; if (o.stall !== 3)          begin n_err++; $display("FAIL rmid_next_stall got=%0d exp=3", o.stall); end
    n_cmp++; if (o.rdm !== 32'h0BADF00D) begin n_err++; $display("FAIL rmid_next_data got=%h exp=0badf00d", o.rdm); end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, o);
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 1'b0, o);
    if (TRAP) begin
      n_cmp++; if (o.misal !== 1'b1)     begin n_err++; $display("FAIL mis_flag got=%b exp=1", o.misal); end
      n_cmp++; if (o.req_seen !== 1'b0)  begin n_err++; $display("FAIL mis_req got=%b exp=0", o.req_seen); end
      n_cmp++; if (o.rdm !== 32'h0)      begin n_err++; $display("FAIL mis_rdm got=%h exp=0", o.rdm); end
      n_cmp++; if (o.stall !== 1)        begin n_err++; $display("FAIL mis_stall got=%0d exp=1", o.stall); end
    end else begin
      n_cmp++; if (o.misal !== 1'b0)       begin n_err++; $display("FAIL mis_flag got=%b exp=0", o.misal); end
      n_cmp++; if (o.addr !== 32'h100)     begin n_err++; $display("FAIL mis_addr got=%h exp=100", o.addr); end
      n_cmp++; if (o.rdm !== 32'h11223344) begin n_err++; $display("FAIL mis_rdm got=%h exp=11223344", o.rdm); end
      n_cmp++; if (o.stall !== 3)          begin n_err++; $display("FAIL mis_stall got=%0d exp=3", o.stall); end
    end
    @(negedge clk); #1;
    n_cmp++; if (MisalignM !== 1'b0) begin n_err++; $display("FAIL mis_pulse got=%b exp=0", MisalignM); end
    run_access(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'hBEEF1234, 0, 0, 1'b0, o);
    n_cmp++; if (o.rdm !== (TRAP ? 32'h0 : 32'hFFFFBEEF))
      begin n_err++; $display("FAIL mis_lh got=%h exp=%h", o.rdm, TRAP ? 32'h0 : 32'hFFFFBEEF); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] model_rd, a, wd, rdat;
    logic [2:0] f3;
    bit ld, st, trapped, is_load;
    int gd, rd, exp_stall;
    do_reset();
    model_rd = 32'h0;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0:       begin ld = 1'b1; st = 1'b0; end
        1:       begin ld = 1'b0; st = 1'b1; end
        default: begin ld = 1'b1; st = 1'b1; end
      endcase
      f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a    = $urandom;
      wd   = $urandom;
      rdat = $urandom;
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      is_load = ld && !st;
      trapped = TRAP && m_misal(f3, a);
      run_access(ld, st, f3, a, wd, rdat, gd, rd, ($urandom_range(0, 1) == 1), o);
      exp_stall = trapped ? 1 : (2 + gd + (is_load ? rd + 1 : 0));
      if (trapped && is_load) model_rd = 32'h0;
      else if (!trapped && is_load) model_rd = m_load(f3, a, rdat);
      n_cmp++; if (o.stall !== exp_stall) begin n_err++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", k, o.stall, exp_stall); end
      n_cmp++; if (o.rdm !== model_rd)    begin n_err++; $display("FAIL rnd%0d_rdm got=%h exp=%h f3=%0d a=%h", k, o.rdm, model_rd, f3, a); end
      n_cmp++; if (o.misal !== trapped)   begin n_err++; $display("FAIL rnd%0d_misal got=%b exp=%b", k, o.misal, trapped); end
      n_cmp++; if (o.req_seen !== !trapped) begin n_err++; $display("FAIL rnd%0d_req got=%b exp=%b", k, o.req_seen, !trapped); end
      if (!trapped) begin
        n_cmp++; if (o.addr !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL rnd%0d_addr got=%h exp=%h", k, o.addr, {a[31:2], 2'b00}); end
        n_cmp++; if (o.we !== st)     begin n_err++; $display("FAIL rnd%0d_we got=%b exp=%b", k, o.we, st); end
        n_cmp++; if (o.stable !== 1'b1) begin n_err++; $display("FAIL rnd%0d_stable got=%b exp=1", k, o.stable); end
        if (st) begin
          n_cmp++; if (o.be !== m_be(f3, a)) begin n_err++; $display("FAIL rnd%0d_be got=%b exp=%b", k, o.be, m_be(f3, a)); end
          n_cmp++; if (o.wdata !== m_wdata(f3, wd)) begin n_err++; $display("FAIL rnd%0d_wdata got=%h exp=%h", k, o.wdata, m_wdata(f3, wd)); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_sw();
    test_lb_lbu();
    test_sh_lhu();
    test_delayed();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
